// File: rtl/vreg_pkg.sv
// Shared types and constants for the video register bus master.
package vreg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RESP   = 3'd4
    } vreg_state_t;

    localparam logic [7:0] VREG_LCDC = 8'h40;
    localparam logic [7:0] VREG_SCY  = 8'h42;
    localparam logic [7:0] VREG_SCX  = 8'h43;
    localparam logic [7:0] VREG_LY   = 8'h44;
    localparam logic [7:0] VREG_LYC  = 8'h45;
    localparam logic [7:0] VREG_WY   = 8'h4A;
    localparam logic [7:0] VREG_WX   = 8'h4B;

    localparam logic [7:0] VREG_OPEN = 8'hFF;

    // Select vector bit order: {ff4b, ff4a, ff45, ff44, ff43, ff42, ff40}
    typedef logic [6:0] vreg_sel_t;

endpackage

// File: rtl/vreg_addr_decode.sv
// Combinational address decode: FFxx low byte + direction to one-hot select.
module vreg_addr_decode
    import vreg_pkg::*;
(
    input  logic [7:0] addr,
    input  logic       we,
    output vreg_sel_t  sel,
    output logic       legal
);

    always_comb begin
        sel = '0;
        case (addr)
            VREG_LCDC: sel = 7'b000_0001;
            VREG_SCY:  sel = 7'b000_0010;
            VREG_SCX:  sel = 7'b000_0100;
            VREG_LY:   sel = 7'b000_1000;
            VREG_LYC:  sel = 7'b001_0000;
            VREG_WY:   sel = 7'b010_0000;
            VREG_WX:   sel = 7'b100_0000;
            default:   sel = '0;
        endcase
        // LY is a read-only counter on the video side
        if (we && (addr == VREG_LY)) begin
            sel = '0;
        end
        legal = |sel;
    end

endmodule

// File: rtl/vreg_bus_master.sv
// CPU-side initiator for the video register latches: decodes one request,
// sequences select/strobe/bus drive, and returns a one-cycle response.
module vreg_bus_master
    import vreg_pkg::*;
#(
    parameter int STROBE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_addr,
    input  logic        req_we,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    inout  tri logic [7:0] d,
    output logic        cpu_rd2,
    output logic        cpu_wr2,
    output logic        ff40,
    output logic        ff42,
    output logic        ff43,
    output logic        ff44,
    output logic        ff45,
    output logic        ff4a,
    output logic        ff4b,
    output vreg_state_t dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE. rsp_valid is a single-cycle pulse, no backpressure.

    localparam logic [2:0] STROBE_LOAD = 3'(STROBE_CYCLES - 1);

    vreg_state_t state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    vreg_sel_t   sel_q, sel_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        err_q, err_d;

    vreg_sel_t   dec_sel;
    logic        dec_legal;
    logic [7:0]  d_sampled;
    logic        active;

    vreg_addr_decode u_decode (
        .addr  (req_addr),
        .we    (req_we),
        .sel   (dec_sel),
        .legal (dec_legal)
    );

    // Undriven (z/x) bits read as 1, as with the board pull-ups
    always_comb begin
        d_sampled = VREG_OPEN;
        for (int i = 0; i < 8; i++) begin
            if (d[i] == 1'b0) begin
                d_sampled[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    sel_d   = dec_sel;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    rdata_d = VREG_OPEN;
                    err_d   = !dec_legal;
                    state_d = dec_legal ? ST_SETUP : ST_RESP;
                end
            end
            ST_SETUP: begin
                cnt_d   = STROBE_LOAD;
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt_q == 3'd0) begin
                    // Final strobe edge: the responder's data is still on the bus
                    if (!we_q) begin
                        rdata_d = d_sampled;
                    end
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_HOLD:  state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= VREG_OPEN;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode straight from flops, so reset clears them asynchronously
    assign active    = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
    assign {ff4b, ff4a, ff45, ff44, ff43, ff42, ff40} = active ? sel_q : '0;
    assign cpu_wr2   = (state_q == ST_STROBE) && we_q;
    assign cpu_rd2   = (state_q == ST_STROBE) && !we_q;
    assign d         = (active && we_q) ? wdata_q : 8'hzz;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rsp_valid ? rdata_q : VREG_OPEN;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vreg_bus_master.sv
// Directed bench for vreg_bus_master: default strobe width plus a one-cycle-strobe instance.
module tb_vreg_bus_master;
    import vreg_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Default instance (STROBE_CYCLES = 2)
    logic        req_valid, req_we, req_ready;
    logic [7:0]  req_addr, req_wdata, rsp_rdata;
    logic        rsp_valid, rsp_err, cpu_rd2, cpu_wr2;
    logic        ff40, ff42, ff43, ff44, ff45, ff4a, ff4b;
    vreg_state_t dbg_state;
    wire  [7:0]  d_bus;

    // One-cycle strobe instance, bus left undriven apart from pull-ups
    logic        req_valid_1, req_we_1, req_ready_1;
    logic [7:0]  req_addr_1, req_wdata_1, rsp_rdata_1;
    logic        rsp_valid_1, rsp_err_1, cpu_rd2_1, cpu_wr2_1;
    logic        ff40_1, ff42_1, ff43_1, ff44_1, ff45_1, ff4a_1, ff4b_1;
    vreg_state_t dbg_state_1;
    wire  [7:0]  d_bus_1;

    for (genvar i = 0; i < 8; i++) begin : g_pull
        pullup pu0 (d_bus[i]);
        pullup pu1 (d_bus_1[i]);
    end

    // Register-file model: FF42 latch, LY reads 0x91, LYC reads 0xC3
    logic [7:0] reg42;
    logic       resp_en;
    logic [7:0] resp_val;
    always_comb begin
        resp_en  = cpu_rd2 && (ff42 || ff44 || ff45);
        resp_val = ff42 ? reg42 : (ff44 ? 8'h91 : 8'hC3);
    end
    assign d_bus = resp_en ? resp_val : 8'hzz;

    always @(posedge clk or posedge reset) begin
        if (reset) reg42 <= 8'h00;
        else if (ff42 && cpu_wr2) reg42 <= d_bus;
    end

    int checks = 0;
    int errors = 0;
    int overlap_cnt = 0;
    int multi_sel_cnt = 0;

    always @(negedge clk) begin
        if (cpu_rd2 && cpu_wr2) overlap_cnt++;
        if ($countones({ff40, ff42, ff43, ff44, ff45, ff4a, ff4b}) > 1) multi_sel_cnt++;
    end

    vreg_bus_master #(.STROBE_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .d(d_bus), .cpu_rd2(cpu_rd2), .cpu_wr2(cpu_wr2),
        .ff40(ff40), .ff42(ff42), .ff43(ff43), .ff44(ff44), .ff45(ff45),
        .ff4a(ff4a), .ff4b(ff4b), .dbg_state(dbg_state)
    );

    vreg_bus_master #(.STROBE_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_1), .req_ready(req_ready_1), .req_addr(req_addr_1),
        .req_we(req_we_1), .req_wdata(req_wdata_1),
        .rsp_valid(rsp_valid_1), .rsp_rdata(rsp_rdata_1), .rsp_err(rsp_err_1),
        .d(d_bus_1), .cpu_rd2(cpu_rd2_1), .cpu_wr2(cpu_wr2_1),
        .ff40(ff40_1), .ff42(ff42_1), .ff43(ff43_1), .ff44(ff44_1), .ff45(ff45_1),
        .ff4a(ff4a_1), .ff4b(ff4b_1), .dbg_state(dbg_state_1)
    );

    task automatic test_reset();
        logic [10:0] obs;
        @(negedge clk);
        obs = {ff40, ff42, ff43, ff44, ff45, ff4a, ff4b, cpu_rd2, cpu_wr2, rsp_valid, rsp_err};
        checks++;
        if (obs !== 11'b0) begin
            errors++; $display("FAIL reset_outputs: got %b want %b", obs, 11'b0);
        end
        checks++;
        if ({req_ready, rsp_rdata, d_bus} !== {1'b1, 8'hFF, 8'hFF}) begin
            errors++; $display("FAIL reset_ready_rdata_bus: got %b %h %h want 1 ff ff", req_ready, rsp_rdata, d_bus);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
        end
        reset = 1'b0;
    endtask

    task automatic test_write_ff42();
        logic [5:0]  exp_ctl, obs_ctl;
        vreg_state_t exp_st;
        logic [7:0]  exp_d;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 8'h42; req_we = 1'b1; req_wdata = 8'h5A;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            exp_ctl = {k <= 4, (k == 2) || (k == 3), 1'b0, k == 5, 1'b0, k == 6};
            obs_ctl = {ff42, cpu_wr2, cpu_rd2, rsp_valid, rsp_err, req_ready};
            checks++;
            if (obs_ctl !== exp_ctl) begin
                errors++; $display("FAIL write_ctl cycle %0d: got %b want %b", k, obs_ctl, exp_ctl);
            end
            exp_d = (k <= 4) ? 8'h5A : 8'hFF;
            checks++;
            if (d_bus !== exp_d) begin
                errors++; $display("FAIL write_bus cycle %0d: got %h want %h", k, d_bus, exp_d);
            end
            exp_st = (k == 1) ? ST_SETUP : (k <= 3) ? ST_STROBE : (k == 4) ? ST_HOLD :
                     (k == 5) ? ST_RESP : ST_IDLE;
            checks++;
            if (dbg_state !== exp_st) begin
                errors++; $display("FAIL write_state cycle %0d: got %0d want %0d", k, dbg_state, exp_st);
            end
            if (k == 5) begin
                checks++;
                if (rsp_rdata !== 8'hFF) begin
                    errors++; $display("FAIL write_rdata: got %h want ff", rsp_rdata);
                end
            end
        end
    endtask

    task automatic test_readback();
        @(negedge clk);
        req_valid = 1'b1; req_addr = 8'h42; req_we = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 2; k <= 5; k++) @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'h5A}) begin
            errors++; $display("FAIL readback_ff42: got %b%b %h want 10 5a", rsp_valid, rsp_err, rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_read_ff44();
        logic [5:0] exp_ctl, obs_ctl;
        logic [7:0] exp_d;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 8'h44; req_we = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            exp_ctl = {k <= 4, 1'b0, (k == 2) || (k == 3), k == 5, 1'b0, k == 6};
            obs_ctl = {ff44, cpu_wr2, cpu_rd2, rsp_valid, rsp_err, req_ready};
            checks++;
            if (obs_ctl !== exp_ctl) begin
                errors++; $display("FAIL read44_ctl cycle %0d: got %b want %b", k, obs_ctl, exp_ctl);
            end
            exp_d = ((k == 2) || (k == 3)) ? 8'h91 : 8'hFF;
            checks++;
            if (d_bus !== exp_d) begin
                errors++; $display("FAIL read44_bus cycle %0d: got %h want %h", k, d_bus, exp_d);
            end
            if (k == 5) begin
                checks++;
                if (rsp_rdata !== 8'h91) begin
                    errors++; $display("FAIL read44_rdata: got %h want 91", rsp_rdata);
                end
            end
        end
    endtask

    task automatic test_errors();
        logic [7:0] a;
        logic [8:0] obs;
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? 8'h44 : 8'h41;
            @(negedge clk);
            req_valid = 1'b1; req_addr = a; req_we = (i == 0);
            req_wdata = 8'h3C;
            @(negedge clk);
            req_valid = 1'b0;
            obs = {ff40, ff42, ff43, ff44, ff45, ff4a, ff4b, cpu_rd2, cpu_wr2};
            checks++;
            if (obs !== 9'b0) begin
                errors++; $display("FAIL err_%h_sel_strobe: got %b want 0", a, obs);
            end
            checks++;
            if ({rsp_valid, rsp_err, req_ready, rsp_rdata, d_bus} !== {3'b110, 8'hFF, 8'hFF}) begin
                errors++; $display("FAIL err_%h_rsp: got %b%b%b %h %h want 110 ff ff",
                                   a, rsp_valid, rsp_err, req_ready, rsp_rdata, d_bus);
            end
            @(negedge clk);
            checks++;
            if ({rsp_valid, req_ready} !== 2'b01) begin
                errors++; $display("FAIL err_%h_ready: got %b%b want 01", a, rsp_valid, req_ready);
            end
        end
    endtask

    task automatic test_strobe1();
        logic [4:0] exp_ctl, obs_ctl;
        @(negedge clk);
        req_valid_1 = 1'b1; req_addr_1 = 8'h40; req_we_1 = 1'b0;
        @(negedge clk);
        req_valid_1 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(negedge clk);
            exp_ctl = {k <= 3, k == 2, 1'b0, k == 4, k == 5};
            obs_ctl = {ff40_1, cpu_rd2_1, cpu_wr2_1, rsp_valid_1, req_ready_1};
            checks++;
            if (obs_ctl !== exp_ctl) begin
                errors++; $display("FAIL n1_ctl cycle %0d: got %b want %b", k, obs_ctl, exp_ctl);
            end
            if (k == 4) begin
                checks++;
                if ({rsp_err_1, rsp_rdata_1} !== {1'b0, 8'hFF}) begin
                    errors++; $display("FAIL n1_rdata: got %b %h want 0 ff", rsp_err_1, rsp_rdata_1);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int rsp_seen;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 8'h40; req_we = 1'b1; req_wdata = 8'h33;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({ff40, cpu_wr2, d_bus} !== {2'b11, 8'h33}) begin
            errors++; $display("FAIL midreset_pre: got %b%b %h want 11 33", ff40, cpu_wr2, d_bus);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({ff40, cpu_wr2, cpu_rd2, rsp_valid, req_ready, d_bus} !== {5'b00001, 8'hFF}) begin
            errors++; $display("FAIL midreset_drop: got %b%b%b%b%b %h want 00001 ff",
                               ff40, cpu_wr2, cpu_rd2, rsp_valid, req_ready, d_bus);
        end
        @(negedge clk);
        reset = 1'b0;
        rsp_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        checks++;
        if (rsp_seen != 0) begin
            errors++; $display("FAIL midreset_no_rsp: got %0d responses want 0", rsp_seen);
        end
        req_valid = 1'b1; req_addr = 8'h45; req_we = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            if (k == 4) begin
                checks++;
                if (rsp_valid !== 1'b0) begin
                    errors++; $display("FAIL postreset_early: got %b want 0", rsp_valid);
                end
            end
        end
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'hC3}) begin
            errors++; $display("FAIL postreset_read: got %b%b %h want 10 c3", rsp_valid, rsp_err, rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_valid = 1'b1; req_addr = 8'h44; req_we = 1'b0;
        @(negedge clk);
        req_addr = 8'h4B; req_we = 1'b1; req_wdata = 8'h77;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) @(negedge clk);
            if (k <= 6) begin
                checks++;
                if (req_ready !== (k == 6)) begin
                    errors++; $display("FAIL b2b_ready cycle %0d: got %b want %b", k, req_ready, k == 6);
                end
            end
            if (k == 5) begin
                checks++;
                if ({rsp_valid, rsp_rdata} !== {1'b1, 8'h91}) begin
                    errors++; $display("FAIL b2b_first_rsp: got %b %h want 1 91", rsp_valid, rsp_rdata);
                end
            end
            if (k == 7) begin
                checks++;
                if ({ff4b, ff44, rsp_valid, d_bus} !== {3'b100, 8'h77}) begin
                    errors++; $display("FAIL b2b_second_setup: got %b%b%b %h want 100 77", ff4b, ff44, rsp_valid, d_bus);
                end
                req_valid = 1'b0;
            end
            if (k == 11) begin
                checks++;
                if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'hFF}) begin
                    errors++; $display("FAIL b2b_second_rsp: got %b%b %h want 10 ff", rsp_valid, rsp_err, rsp_rdata);
                end
            end
        end
        checks++;
        if ({overlap_cnt, multi_sel_cnt} != 64'd0) begin
            errors++; $display("FAIL strobe_select_exclusive: got %0d overlaps %0d multi-selects want 0 0",
                               overlap_cnt, multi_sel_cnt);
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_addr = 8'h00; req_we = 1'b0; req_wdata = 8'h00;
        req_valid_1 = 1'b0; req_addr_1 = 8'h00; req_we_1 = 1'b0; req_wdata_1 = 8'h00;
        test_reset();
        test_write_ff42();
        test_readback();
        test_read_ff44();
        test_errors();
        test_strobe1();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vreg_bus_master.md
# vreg_bus_master

CPU-side initiator for the video register file (LCDC FF40, SCY FF42, SCX FF43, LY FF44, LYC FF45, WY FF4A, WX FF4B). It takes single register-access requests from a simple valid/ready interface, decodes the address, and drives the one-hot register selects, `cpu_rd2`/`cpu_wr2` strobes and the shared tri-state data bus. It samples read data and returns a one-cycle response. It is the write/read-side counterpart of the video register latches, and drives them directly.

## Interface
Parameters:
- `STROBE_CYCLES`, default 2: number of cycles `cpu_rd2`/`cpu_wr2` stay high per access. Legal range is 1–7.

Ports (clock and reset first):
- `clk`  in  1  system clock. All state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  access request present.
- `req_ready`  out  1  block can accept a request.
- `req_addr`  in  8  low byte of the FFxx address.
- `req_we`  in  1  1 = write, 0 = read.
- `req_wdata`  in  8  write data.
- `rsp_valid`  out  1  one-cycle response pulse. There is no backpressure on responses.
- `rsp_rdata`  out  8  read data. It is 8'hFF on writes and on errors.
- `rsp_err`  out  1  access was rejected (unmapped address, or write to FF44).
- `d`  inout  8  shared CPU data bus (`inout tri logic`). Driven only during write access cycles.
- `cpu_rd2`, `cpu_wr2`  out  1  read and write strobes.
- `ff40`, `ff42`, `ff43`, `ff44`, `ff45`, `ff4a`, `ff4b`  out  1  one-hot register selects.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, RESP.
- `req_ready` is 1 only in IDLE. A request is accepted when `req_valid && req_ready`. On acceptance, `req_addr`, `req_we` and `req_wdata` are captured.
- **IDLE → SETUP**: taken for a legal access. The matching select is asserted; for a write, the captured data is driven on `d`.
- **IDLE → RESP**: taken for an illegal access, with `rsp_err=1`. No select, strobe or bus drive occurs. Illegal means any address outside {40,42,43,44,45,4A,4B}, or a write to 44.
- **SETUP → STROBE**: `cpu_rd2` or `cpu_wr2` is asserted. The strobe holds for `STROBE_CYCLES` cycles, counted by a 3-bit down-counter.
- **STROBE → HOLD**: the strobe drops. The select and the write data are held for one further cycle, so the latches close on stable data.
- **HOLD → RESP**: the select drops and `d` is released. For a read, `rsp_rdata` is the value of `d` sampled on the final STROBE edge.
- **RESP → IDLE**: unconditional.
- Read sampling: any bus bit that is z or x is returned as 1 (bus pull-up semantics).
- At most one select and one strobe are active at any time. `cpu_rd2` and `cpu_wr2` are never high together.

## Timing
- Cycle 0 is the acceptance edge. With N = `STROBE_CYCLES`:
  - SETUP is cycle 1.
  - STROBE is cycles 2..N+1.
  - HOLD is cycle N+2.
  - `rsp_valid` is high in cycle N+3.
  - `req_ready` is high again in cycle N+4.
- With the default N=2, a legal access has a 5-cycle response latency and a 6-cycle issue interval.
- Error path: `rsp_valid` is high in cycle 1, and `req_ready` is high again in cycle 2.
- Reset values: `req_ready=1`; `rsp_valid=0`; `rsp_err=0`; `rsp_rdata=8'hFF`; all selects and strobes 0; `d` high-Z.
- Reset mid-access: all outputs return to their reset values immediately (asynchronously). Any pending response is dropped.
- `req_valid` in a non-IDLE state is ignored. Requests are never lost once accepted.

## Structure
- Package `vreg_pkg` contains:
  - the state enum `vreg_state_t`;
  - address constants `VREG_LCDC=8'h40`, `VREG_SCY=8'h42`, `VREG_SCX=8'h43`, `VREG_LY=8'h44`, `VREG_LYC=8'h45`, `VREG_WY=8'h4A`, `VREG_WX=8'h4B`;
  - the bus value `VREG_OPEN=8'hFF`.
- Sub-module `vreg_addr_decode` is combinational. It maps address + we to a 7-bit one-hot select and a `legal` flag. The top level registers its outputs at acceptance.

## Test plan
- Write FF42 with 0x5A, default N → SETUP at cycle 1, `ff42` high in cycles 1–4, `cpu_wr2` high in cycles 2–3, `d`=0x5A in cycles 1–4 and Z at cycle 5. `rsp_valid` at cycle 5 with `rsp_err=0` and `rsp_rdata=0xFF`. The attached register latch reads back 0x5A.
- Read FF44 with the responder driving 0x91 → `ff44` high in cycles 1–4, `cpu_rd2` high in cycles 2–3, `d` never driven by the block. `rsp_rdata=0x91` at cycle 5.
- Write FF44, then read FF41 → each gives `rsp_valid` at cycle 1 with `rsp_err=1`, `rsp_rdata=0xFF`, and zero selects or strobes.
- Read with an undriven bus, and `STROBE_CYCLES=1` → `rsp_rdata=0xFF` at cycle 4, and `req_ready` returns at cycle 5.
- Assert `reset` during cycle 3 of a write → strobe, select and bus drive drop immediately, and no `rsp_valid` follows. After release, a new read completes normally.
- Back-to-back requests with `req_valid` held high → a second access is accepted exactly at cycle 6, and `cpu_rd2`/`cpu_wr2` are never high together.
